systolic_fpga_example_lane_accum: RTL and testbench



---
 rtl/systolic_fpga_example_lane_accum.sv | 116 +++++++++++
 tb/tb_systolic_fpga_example_lane_accum.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_fpga_example_lane_accum.sv
// Per-lane packet accumulator for a 512-bit AXI4-Stream: sums each lane across a tlast-terminated
// packet and emits one registered result beat. Define LANE_ACCUM_SATURATE_EN for saturating lane adds.
module systolic_fpga_example_lane_accum #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
    parameter int unsigned C_LANE_BIT_WIDTH   = 32,
    parameter int unsigned C_BEAT_CNT_WIDTH   = 16
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                              s_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic [31:0]                       stat_pkt_count,
    output logic [C_BEAT_CNT_WIDTH-1:0]       stat_last_beats
);

    localparam int unsigned LW = C_LANE_BIT_WIDTH;
    localparam int unsigned NL = C_AXIS_TDATA_WIDTH / C_LANE_BIT_WIDTH;
    localparam int unsigned KB = C_LANE_BIT_WIDTH / 8;
    localparam int unsigned KW = C_AXIS_TDATA_WIDTH / 8;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t                          r_state;
    logic [C_AXIS_TDATA_WIDTH-1:0]   r_acc;
    logic [C_AXIS_TDATA_WIDTH-1:0]   w_sum;
    logic [C_BEAT_CNT_WIDTH-1:0]     r_beat_cnt;
    logic [C_BEAT_CNT_WIDTH-1:0]     w_cnt_next;
    logic [C_AXIS_TDATA_WIDTH-1:0]   r_m_tdata;
    logic [KW-1:0]                   r_m_tkeep;
    logic                            r_m_tvalid;
    logic                            r_m_tlast;
    logic [31:0]                     r_pkt_count;
    logic [C_BEAT_CNT_WIDTH-1:0]     r_last_beats;
    logic                            w_s_tready;
    logic                            w_accept;
    logic                            w_complete;

    assign w_s_tready = ~areset & (~r_m_tvalid | m_axis_tready);
    assign w_accept   = s_axis_tvalid & w_s_tready;
    assign w_complete = w_accept & s_axis_tlast;

    // First beat of a packet restarts the count at 1; afterwards it saturates at all-ones.
    assign w_cnt_next = (r_state == S_IDLE) ? C_BEAT_CNT_WIDTH'(1)
                      : ((&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + 1'b1);

    genvar g;
    for (g = 0; g < NL; g++) begin : g_lane
        logic          w_lane_en;
        logic [LW-1:0] w_lane;
        logic [LW-1:0] w_base;

        assign w_lane_en = &s_axis_tkeep[g*KB +: KB];
        assign w_lane    = w_lane_en ? s_axis_tdata[g*LW +: LW] : '0;
        assign w_base    = (r_state == S_IDLE) ? '0 : r_acc[g*LW +: LW];
`ifdef LANE_ACCUM_SATURATE_EN
        logic [LW:0] w_add;
        assign w_add = {1'b0, w_base} + {1'b0, w_lane};
        assign w_sum[g*LW +: LW] = w_add[LW] ? '1 : w_add[LW-1:0];
`else
        assign w_sum[g*LW +: LW] = w_base + w_lane;
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_beat_cnt   <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tkeep    <= '0;
            r_m_tlast    <= 1'b0;
            r_pkt_count  <= '0;
            r_last_beats <= '0;
        end else begin
            if (w_accept) begin
                r_acc      <= w_sum;
                r_beat_cnt <= w_cnt_next;
                r_state    <= s_axis_tlast ? S_IDLE : S_ACCUM;
            end
            // A completion reloads the output even while the previous result transfers.
            if (w_complete) begin
                r_m_tvalid   <= 1'b1;
                r_m_tdata    <= w_sum;
                r_m_tkeep    <= '1;
                r_m_tlast    <= 1'b1;
                r_last_beats <= w_cnt_next;
                r_pkt_count  <= r_pkt_count + 32'd1;
            end else if (r_m_tvalid & m_axis_tready) begin
                r_m_tvalid <= 1'b0;
                r_m_tkeep  <= '0;
                r_m_tlast  <= 1'b0;
            end
        end
    end

    assign s_axis_tready   = w_s_tready;
    assign m_axis_tvalid   = r_m_tvalid;
    assign m_axis_tdata    = r_m_tdata;
    assign m_axis_tkeep    = r_m_tkeep;
    assign m_axis_tlast    = r_m_tlast;
    assign stat_pkt_count  = r_pkt_count;
    assign stat_last_beats = r_last_beats;

endmodule

// File: tb/tb_systolic_fpga_example_lane_accum.sv
// Self-checking bench for systolic_fpga_example_lane_accum: table vectors, corner sequences and
// randomized packets scored against a per-lane arithmetic model.
module tb_systolic_fpga_example_lane_accum;

    localparam int unsigned W   = 512;
    localparam int unsigned KW  = 64;
    localparam int unsigned NL  = 16;
    localparam int unsigned BCW = 4;

    logic            aclk = 1'b0;
    logic            areset;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [W-1:0]    s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [W-1:0]    m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tlast;
    logic [31:0]     stat_pkt_count;
    logic [BCW-1:0]  stat_last_beats;

    systolic_fpga_example_lane_accum #(
        .C_AXIS_TDATA_WIDTH (W),
        .C_LANE_BIT_WIDTH   (32),
        .C_BEAT_CNT_WIDTH   (BCW)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tlast    (s_axis_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .stat_pkt_count  (stat_pkt_count),
        .stat_last_beats (stat_last_beats)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [W-1:0] d;
        int unsigned  beats;
    } exp_t;

    typedef struct {
        logic [31:0] lane_val;
        logic [63:0] keep;
        logic [31:0] exp_val;
        logic [15:0] exp_mask;
    } vec_t;

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    int unsigned  mon_pkts = 0;
    bit           rnd_mode = 0;
    exp_t         exp_q[$];
    logic [W-1:0] pkt_d[$];
    logic [KW-1:0] pkt_k[$];
    vec_t         vecs[5];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [31:0] v, input logic [15:0] m);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) r[i*32 +: 32] = m[i] ? v : 32'd0;
        return r;
    endfunction

    // Reference: each lane is the plain sum of its fully-kept words over the packet.
    function automatic exp_t model_pkt();
        exp_t e;
        e.d = '0;
        for (int ln = 0; ln < NL; ln++) begin
            longint unsigned s = 0;
            for (int b = 0; b < pkt_d.size(); b++)
                if (pkt_k[b][ln*4 +: 4] == 4'hF) s += longint'(pkt_d[b][ln*32 +: 32]);
`ifdef LANE_ACCUM_SATURATE_EN
            if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`endif
            e.d[ln*32 +: 32] = s[31:0];
        end
        e.beats = (pkt_d.size() > (2**BCW - 1)) ? (2**BCW - 1) : pkt_d.size();
        return e;
    endfunction

    task automatic push_exp(input logic [W-1:0] d, input int unsigned beats);
        exp_t e;
        e.d = d;
        e.beats = beats;
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
        int unsigned n;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!s_axis_tready && n < 200) begin
            @(posedge aclk); #1;
            if (rnd_mode) m_axis_tready = ($urandom_range(0, 3) != 0);
            @(negedge aclk);
            n++;
        end
        if (!s_axis_tready) chk("send_beat_timeout", {511'd0, s_axis_tready}, {511'd0, 1'b1});
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        if (rnd_mode) m_axis_tready = $urandom_range(0, 1);
    endtask

    task automatic send_packet();
        for (int b = 0; b < pkt_d.size(); b++)
            send_beat(pkt_d[b], pkt_k[b], (b == pkt_d.size() - 1));
        exp_q.push_back(model_pkt());
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        chk("rst_tvalid", {511'd0, m_axis_tvalid}, '0);
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_tkeep", {448'd0, m_axis_tkeep}, '0);
        chk("rst_tlast", {511'd0, m_axis_tlast}, '0);
        chk("rst_pkt_count", {480'd0, stat_pkt_count}, '0);
        chk("rst_last_beats", {508'd0, stat_last_beats}, '0);
        chk("rst_s_tready", {511'd0, s_axis_tready}, '0);
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n;
        n = 0;
        while ((m_axis_tvalid || exp_q.size() != 0) && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", {480'd0, exp_q.size()}, '0);
        @(posedge aclk); #1;
    endtask

    initial begin
        vecs[0] = '{32'd5,         64'h0000_0000_0000_FFF7, 32'd5,         16'h000E};
        vecs[1] = '{32'd7,         64'hFFFF_FFFF_FFFF_FFFF, 32'd7,         16'hFFFF};
        vecs[2] = '{32'hDEAD_BEEF, 64'hF0F0_F0F0_F0F0_F0F0, 32'hDEAD_BEEF, 16'hAAAA};
        vecs[3] = '{32'd9,         64'h0000_0000_0000_0000, 32'd9,         16'h0000};
        vecs[4] = '{32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF};

        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;

        fork
            forever begin
                @(negedge aclk);
                if (areset) begin
                    mon_pkts = 0;
                    exp_q.delete();
                end else if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("mon_unexpected_beat", {511'd0, m_axis_tvalid}, '0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("mon_tdata", m_axis_tdata, e.d);
                        chk("mon_tkeep", {448'd0, m_axis_tkeep}, {448'd0, {KW{1'b1}}});
                        chk("mon_tlast", {511'd0, m_axis_tlast}, {511'd0, 1'b1});
                        chk("mon_last_beats", {508'd0, stat_last_beats}, W'(e.beats));
                        chk("mon_pkt_count", {480'd0, stat_pkt_count}, W'(mon_pkts + 1));
                        mon_pkts++;
                    end
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        @(posedge aclk); #1;
        do_reset();

        // Three-beat packet 1,2,3 -> every lane 6, result one cycle after the tlast beat.
        send_beat(rep(32'd1, 16'hFFFF), '1, 1'b0);
        send_beat(rep(32'd2, 16'hFFFF), '1, 1'b0);
        chk("t1_no_early_valid", {511'd0, m_axis_tvalid}, '0);
        send_beat(rep(32'd3, 16'hFFFF), '1, 1'b1);
        push_exp(rep(32'd6, 16'hFFFF), 3);
        chk("t1_valid", {511'd0, m_axis_tvalid}, {511'd0, 1'b1});
        chk("t1_data", m_axis_tdata, rep(32'd6, 16'hFFFF));
        chk("t1_keep", {448'd0, m_axis_tkeep}, {448'd0, {KW{1'b1}}});
        chk("t1_last", {511'd0, m_axis_tlast}, {511'd0, 1'b1});
        chk("t1_pkt_count", {480'd0, stat_pkt_count}, W'(1));
        chk("t1_last_beats", {508'd0, stat_last_beats}, W'(3));
        wait_drain();

        // Lane 0 wrap (or saturation) across two beats.
        send_beat(rep(32'hFFFF_FFFF, 16'h0001), '1, 1'b0);
        send_beat(rep(32'h0000_0002, 16'h0001), '1, 1'b1);
`ifdef LANE_ACCUM_SATURATE_EN
        push_exp(rep(32'hFFFF_FFFF, 16'h0001), 2);
        chk("t2_wrap", m_axis_tdata, rep(32'hFFFF_FFFF, 16'h0001));
`else
        push_exp(rep(32'h0000_0001, 16'h0001), 2);
        chk("t2_wrap", m_axis_tdata, rep(32'h0000_0001, 16'h0001));
`endif
        wait_drain();

        // Single-beat table vectors covering keep patterns.
        for (int i = 0; i < 5; i++) begin
            pkt_d.delete();
            pkt_k.delete();
            pkt_d.push_back(rep(vecs[i].lane_val, 16'hFFFF));
            pkt_k.push_back(vecs[i].keep);
            send_packet();
            chk($sformatf("vec%0d_data", i), m_axis_tdata, rep(vecs[i].exp_val, vecs[i].exp_mask));
            chk($sformatf("vec%0d_beats", i), {508'd0, stat_last_beats}, W'(1));
            wait_drain();
        end

        // Backpressure: result held, next beat refused, then transfer and accept in one cycle.
        m_axis_tready = 1'b0;
        send_beat(rep(32'd11, 16'hFFFF), '1, 1'b1);
        push_exp(rep(32'd11, 16'hFFFF), 1);
        s_axis_tdata  = rep(32'd12, 16'hFFFF);
        s_axis_tkeep  = '1;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        push_exp(rep(32'd12, 16'hFFFF), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("bp_s_tready_low", {511'd0, s_axis_tready}, '0);
            chk("bp_data_stable", m_axis_tdata, rep(32'd11, 16'hFFFF));
            chk("bp_valid_held", {511'd0, m_axis_tvalid}, {511'd0, 1'b1});
        end
        @(posedge aclk); #1;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        chk("bp_s_tready_high", {511'd0, s_axis_tready}, {511'd0, 1'b1});
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        chk("bp_reload_valid", {511'd0, m_axis_tvalid}, {511'd0, 1'b1});
        chk("bp_reload_data", m_axis_tdata, rep(32'd12, 16'hFFFF));
        wait_drain();

        // Back-to-back single-beat packets with no bubble.
        do_reset();
        send_beat(rep(32'd7, 16'hFFFF), '1, 1'b1);
        push_exp(rep(32'd7, 16'hFFFF), 1);
        chk("b2b_valid0", {511'd0, m_axis_tvalid}, {511'd0, 1'b1});
        chk("b2b_data0", m_axis_tdata, rep(32'd7, 16'hFFFF));
        send_beat(rep(32'd9, 16'hFFFF), '1, 1'b1);
        push_exp(rep(32'd9, 16'hFFFF), 1);
        chk("b2b_valid1", {511'd0, m_axis_tvalid}, {511'd0, 1'b1});
        chk("b2b_data1", m_axis_tdata, rep(32'd9, 16'hFFFF));
        chk("b2b_pkt_count", {480'd0, stat_pkt_count}, W'(2));
        wait_drain();

        // Reset mid-packet discards partial sums.
        send_beat(rep(32'd4, 16'hFFFF), '1, 1'b0);
        send_beat(rep(32'd4, 16'hFFFF), '1, 1'b0);
        do_reset();
        send_beat(rep(32'd1, 16'hFFFF), '1, 1'b1);
        push_exp(rep(32'd1, 16'hFFFF), 1);
        chk("mid_rst_data", m_axis_tdata, rep(32'd1, 16'hFFFF));
        chk("mid_rst_pkt_count", {480'd0, stat_pkt_count}, W'(1));
        wait_drain();

        // Beat counter saturation with a 20-beat packet.
        pkt_d.delete();
        pkt_k.delete();
        for (int b = 0; b < 20; b++) begin
            pkt_d.push_back(rep(32'd1, 16'hFFFF));
            pkt_k.push_back('1);
        end
        send_packet();
        chk("sat_cnt_data", m_axis_tdata, rep(32'd20, 16'hFFFF));
        chk("sat_cnt_beats", {508'd0, stat_last_beats}, W'(15));
        wait_drain();

        // Randomized packets with random downstream backpressure.
        rnd_mode = 1;
        for (int p = 0; p < 40; p++) begin
            int unsigned len;
            len = $urandom_range(1, 6);
            pkt_d.delete();
            pkt_k.delete();
            for (int b = 0; b < len; b++) begin
                logic [W-1:0]  d;
                logic [KW-1:0] k;
                for (int ln = 0; ln < NL; ln++) begin
                    d[ln*32 +: 32] = $urandom;
                    case ($urandom_range(0, 3))
                        0, 1:    k[ln*4 +: 4] = 4'hF;
                        2:       k[ln*4 +: 4] = 4'h0;
                        default: k[ln*4 +: 4] = 4'($urandom_range(0, 15));
                    endcase
                end
                pkt_d.push_back(d);
                pkt_k.push_back(k);
            end
            send_packet();
        end
        rnd_mode = 0;
        m_axis_tready = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
